// File: rtl/gate_tester_if.sv
// gate_tester_if: bundles the signals between gate_tester and its environment.
//   start, op      run request and expected gate function (environment -> tester)
//   y_dut          output of the gate under test (gate -> tester)
//   stim           gate input vector (tester -> gate), bit 0 -> a, bit 1 -> b, ...
//   busy, done     run in progress / one-cycle end-of-run pulse
//   pass           last completed run had zero mismatches
//   err_count      mismatches in the current or last run
//   first_fail     stim value of the first mismatch, valid when first_fail_vld
// The master modport belongs to the side that issues runs and models the gate;
// the slave modport belongs to gate_tester.
interface gate_tester_if #(
    parameter int N_IN = 2
);
    logic            start;
    logic [2:0]      op;
    logic            y_dut;
    logic [N_IN-1:0] stim;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   err_count;
    logic [N_IN-1:0] first_fail;
    logic            first_fail_vld;

    modport master (
        output start, op, y_dut,
        input  stim, busy, done, pass, err_count, first_fail, first_fail_vld
    );

    modport slave (
        input  start, op, y_dut,
        output stim, busy, done, pass, err_count, first_fail, first_fail_vld
    );
endinterface

// File: rtl/gate_tester.sv
// gate_tester: exhaustive stimulus/response checker for a combinational gate.
// Walks stim through 0 .. 2^N_IN-1, holds each vector SETTLE cycles, samples
// y_dut on the last cycle of each vector and compares it with the selected
// reduction function (op: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6/7 -> 0).
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    gate_tester_if slave modport (see gate_tester_if.sv)
module gate_tester #(
    parameter int N_IN   = 2,
    parameter int SETTLE = 2
) (
    input logic          clk,
    input logic          rst_n,
    gate_tester_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int                CNT_W     = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(SETTLE - 1);
    localparam logic [N_IN-1:0]   STIM_LAST = '1;

    state_t          state_q, state_d;
    logic [2:0]      op_q;
    logic [CNT_W-1:0] cnt_q;
    logic [N_IN-1:0] stim_q;
    logic            busy_q, done_q, pass_q;
    logic [N_IN:0]   err_q;
    logic [N_IN-1:0] ff_q;
    logic            ffv_q;

    logic            sample_edge;
    logic            last_vec;
    logic            expected;
    logic            mismatch;
    logic [N_IN:0]   err_next;

    function automatic logic exp_fn(input logic [2:0] f, input logic [N_IN-1:0] v);
        case (f)
            3'd0:    return  (&v);
            3'd1:    return  (|v);
            3'd2:    return ~(&v);
            3'd3:    return ~(|v);
            3'd4:    return  (^v);
            3'd5:    return ~(^v);
            default: return 1'b0;
        endcase
    endfunction

    assign sample_edge = (state_q == RUN) && (cnt_q == '0);
    assign last_vec    = (stim_q == STIM_LAST);
    assign expected    = exp_fn(op_q, stim_q);
    assign mismatch    = sample_edge && (bus.y_dut != expected);
    // err_next includes the final vector's mismatch so pass reflects the full run.
    assign err_next    = err_q + (N_IN+1)'(mismatch);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: next state gets its default first, so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (sample_edge && last_vec) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= '0;
            cnt_q  <= '0;
            stim_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
            err_q  <= '0;
            ff_q   <= '0;
            ffv_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        op_q   <= bus.op;
                        stim_q <= '0;
                        cnt_q  <= CNT_LOAD;
                        err_q  <= '0;
                        ff_q   <= '0;
                        ffv_q  <= 1'b0;
                        pass_q <= 1'b0;
                        busy_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        err_q <= err_next;
                        if (mismatch && !ffv_q) begin
                            ff_q  <= stim_q;
                            ffv_q <= 1'b1;
                        end
                        if (last_vec) begin
                            // stim stays at all ones until the next accepted start.
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            pass_q <= (err_next == '0);
                        end else begin
                            stim_q <= stim_q + N_IN'(1);
                            cnt_q  <= CNT_LOAD;
                        end
                    end
                end
                DONE: done_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign bus.stim           = stim_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.pass           = pass_q;
    assign bus.err_count      = err_q;
    assign bus.first_fail     = ff_q;
    assign bus.first_fail_vld = ffv_q;
endmodule

// File: tb/tb_gate_tester.sv
// Testbench for gate_tester: two instances (N_IN=2/SETTLE=2 and N_IN=3/SETTLE=1).
// Stimulus pushes the expected run result into a per-DUT queue; a monitor pops
// and compares whenever that DUT pulses done.
module tb_gate_tester;
    typedef struct {
        int err;
        int pass;
        int ff;
        int ffv;
        int k;
    } exp_t;

    typedef enum int {M_AND, M_ONE, M_ZERO} model_t;

    localparam int LAT = 8;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    int     cyc = 0;
    int     n_checks = 0;
    int     n_fail = 0;
    model_t mode1 = M_AND;
    exp_t   q1[$];
    exp_t   q2[$];

    gate_tester_if #(.N_IN(2)) bus1 ();
    gate_tester_if #(.N_IN(3)) bus2 ();

    gate_tester #(.N_IN(2), .SETTLE(2)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    gate_tester #(.N_IN(3), .SETTLE(1)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Gate models: 2-input AND or a stuck output for dut1, 3-input XOR for dut2.
    assign bus1.y_dut = (mode1 == M_AND) ? (bus1.stim == 2'b11) : (mode1 == M_ONE);
    assign bus2.y_dut = bus2.stim[0] ^ bus2.stim[1] ^ bus2.stim[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic start1(input logic [2:0] op, output int k);
        @(negedge clk);
        bus1.op    = op;
        bus1.start = 1'b1;
        k          = cyc + 1;
        @(negedge clk);
        bus1.start = 1'b0;
    endtask

    task automatic push1(input int err, input int pass, input int ff, input int ffv, input int k);
        exp_t e;
        e.err = err; e.pass = pass; e.ff = ff; e.ffv = ffv; e.k = k;
        q1.push_back(e);
    endtask

    task automatic drain(input int which);
        for (int i = 0; i < 40; i++) begin
            if ((which == 1 ? q1.size() : q2.size()) == 0) break;
            @(negedge clk);
        end
        check(which == 1 ? "dut1 result timeout" : "dut2 result timeout",
              which == 1 ? q1.size() : q2.size(), 0);
        // Extra idle cycles expose any spurious second done pulse.
        repeat (4) @(negedge clk);
    endtask

    initial begin : mon1
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && bus1.done === 1'b1) begin
                if (q1.size() == 0) begin
                    check("dut1 unexpected done", 1, 0);
                end else begin
                    e = q1.pop_front();
                    check("dut1 done cycle", cyc, e.k + LAT);
                    check("dut1 busy at done", bus1.busy, 0);
                    check("dut1 err_count", bus1.err_count, e.err);
                    check("dut1 pass", bus1.pass, e.pass);
                    check("dut1 first_fail_vld", bus1.first_fail_vld, e.ffv);
                    check("dut1 first_fail", bus1.first_fail, e.ff);
                end
            end
        end
    end

    initial begin : mon2
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && bus2.done === 1'b1) begin
                if (q2.size() == 0) begin
                    check("dut2 unexpected done", 1, 0);
                end else begin
                    e = q2.pop_front();
                    check("dut2 done cycle", cyc, e.k + LAT);
                    check("dut2 err_count", bus2.err_count, e.err);
                    check("dut2 pass", bus2.pass, e.pass);
                    check("dut2 first_fail_vld", bus2.first_fail_vld, e.ffv);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int   k;
        exp_t e;
        bus1.start = 1'b0;
        bus1.op    = 3'd0;
        bus2.start = 1'b0;
        bus2.op    = 3'd0;

        #3;
        check("reset stim", bus1.stim, 0);
        check("reset busy", bus1.busy, 0);
        check("reset done", bus1.done, 0);
        check("reset pass", bus1.pass, 0);
        check("reset err_count", bus1.err_count, 0);
        check("reset first_fail_vld", bus1.first_fail_vld, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Correct AND gate, op AND: clean run, stim stepping and busy profile checked.
        mode1 = M_AND;
        start1(3'd0, k);
        push1(0, 1, 0, 0, k);
        for (int j = 0; j <= 8; j++) begin
            if (j > 0) @(negedge clk);
            check($sformatf("and stim j=%0d", j), bus1.stim, (j / 2 > 3) ? 3 : j / 2);
            check($sformatf("and busy j=%0d", j), bus1.busy, (j < 8) ? 1 : 0);
        end
        drain(1);
        check("stim held after run", bus1.stim, 3);
        check("pass held after run", bus1.pass, 1);

        // AND gate checked as OR: vectors 01 and 10 mismatch.
        start1(3'd1, k);
        push1(2, 0, 1, 1, k);
        drain(1);

        // Output stuck at 1, op AND: 00, 01, 10 mismatch.
        mode1 = M_ONE;
        start1(3'd0, k);
        push1(3, 0, 0, 1, k);
        drain(1);

        // Output stuck at 0, op NOR: only 00 mismatches.
        mode1 = M_ZERO;
        start1(3'd3, k);
        push1(1, 0, 0, 1, k);
        drain(1);

        // AND gate checked as NAND (every vector mismatches); start and op
        // disturbed mid-run, at the last sample edge and in the DONE cycle.
        mode1 = M_AND;
        start1(3'd2, k);
        push1(4, 0, 0, 1, k);
        wait_until(k + 2);
        bus1.start = 1'b1;
        bus1.op    = 3'd0;
        @(negedge clk);
        bus1.start = 1'b0;
        wait_until(k + 7);
        bus1.start = 1'b1;
        wait_until(k + 9);
        bus1.start = 1'b0;
        drain(1);
        check("no restart after DONE", bus1.busy, 0);

        // Reset during a run: everything clears immediately, no done follows.
        start1(3'd0, k);
        wait_until(k + 4);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort stim", bus1.stim, 0);
        check("abort busy", bus1.busy, 0);
        check("abort done", bus1.done, 0);
        check("abort err_count", bus1.err_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("no done after abort", q1.size(), 0);

        // Clean run after the abort, op OR with stuck-1 output: only 00 mismatches.
        mode1 = M_ONE;
        start1(3'd1, k);
        push1(1, 0, 0, 1, k);
        drain(1);

        // Second instance: 3-input XOR gate, op XOR, one cycle per vector.
        @(negedge clk);
        bus2.op    = 3'd4;
        bus2.start = 1'b1;
        k          = cyc + 1;
        @(negedge clk);
        bus2.start = 1'b0;
        e.err = 0; e.pass = 1; e.ff = 0; e.ffv = 0; e.k = k;
        q2.push_back(e);
        for (int j = 0; j <= 8; j++) begin
            if (j > 0) @(negedge clk);
            check($sformatf("xor stim j=%0d", j), bus2.stim, (j > 7) ? 7 : j);
        end
        drain(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/gate_tester.md
Name: gate_tester

Overview:
- Self-checking stimulus/response stage for the combinational gate blocks: drives the gate inputs with every input combination, samples the gate output after a settle interval, and compares it against the expected truth table for a selected function.
- Sits directly around the gate under test. Its stim bus feeds the gate inputs (a, b, ...), and the gate output y returns on y_dut.
- Reports pass/fail, the error count, and the first failing vector for on-chip or FPGA self-test of gate cells.

Parameters:
- N_IN, 2, number of gate inputs driven (1..8); 2^N_IN vectors per run.
- SETTLE, 2, cycles each vector is held before y_dut is sampled (>=1).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  level-sampled run request; honoured only in IDLE.
- op  input  3  expected function: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6/7 reserved (expected = 0).
- y_dut  input  1  gate output under test.
- stim  output  N_IN  gate input vector; bit 0 -> a, bit 1 -> b, ...
- busy  output  1  high while a run is in progress.
- done  output  1  one-cycle pulse at run end.
- pass  output  1  1 if the last completed run had zero mismatches.
- err_count  output  N_IN+1  mismatches in the current or last run.
- first_fail  output  N_IN  stim value of the first mismatch.
- first_fail_vld  output  1  first_fail holds a valid vector.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE.
  - stim, busy, done, pass, err_count, first_fail, first_fail_vld = 0.
  - Reset mid-run aborts the run immediately; no done pulse is issued.
- FSM states: IDLE, RUN, DONE.
- IDLE, start = 1 at an edge:
  - op is latched into op_q and held for the whole run; later op changes are ignored until the next start.
  - stim <= 0, settle counter <= SETTLE-1.
  - err_count <= 0, first_fail_vld <= 0, first_fail <= 0, pass <= 0, busy <= 1.
  - Next state is RUN.
- RUN, counter != 0: decrement the counter; stim is held.
- RUN, counter == 0 (sample edge):
  - exp = f(op_q, stim), where f is the reduction AND/OR/XOR of stim, or its inversion for NAND/NOR/XNOR.
  - If y_dut != exp: err_count increments. If first_fail_vld = 0, also first_fail <= stim and first_fail_vld <= 1.
  - If stim == 2^N_IN - 1: next state DONE, busy <= 0, done <= 1, and pass <= (final err_count == 0), including the mismatch on this final vector.
  - Otherwise: stim <= stim + 1, counter <= SETTLE-1.
- DONE (one cycle): done = 1, busy = 0, then go to IDLE with done <= 0. start is ignored in this cycle.
- start while busy or in DONE: ignored. No restart, no queueing.
- Latency:
  - Each vector is presented for exactly SETTLE cycles.
  - Last sample lands at start edge + 2^N_IN * SETTLE.
  - done is high for the cycle immediately after that edge.
- Hold and wrap:
  - stim holds its last value (all ones) after the run; it does not wrap to 0 until the next start.
  - Results (pass, err_count, first_fail, first_fail_vld) hold until the next accepted start.
- err_count width N_IN+1 holds the maximum count 2^N_IN without saturation.
- y_dut is sampled only on sample edges; its value at other cycles is don't-care.

Test Plan (N_IN=2, SETTLE=2 unless stated):
- Correct AND model on stim, op=0, start pulse at edge k -> stim steps 00,01,10,11 each for 2 cycles; done high only in cycle k+8..k+9; err_count=0, pass=1, first_fail_vld=0.
- AND model, op=1 (OR) -> mismatches on 01 and 10; err_count=2, first_fail=01, first_fail_vld=1, pass=0.
- y_dut tied to 1, op=0 -> err_count=3, first_fail=00, pass=0. y_dut tied to 0, op=3 (NOR) -> err_count=1, first_fail=00.
- start re-asserted at edges k+3 and k+8 and op changed mid-run -> run unaffected, single done at k+8, results match the op latched at k.
- rst_n pulled low at edge k+5 -> all outputs 0 immediately with no done; next start runs a clean full sequence.
- SETTLE=1, N_IN=3, XOR model, op=4 -> 8 vectors on consecutive cycles, done in cycle k+8..k+9, err_count=0, pass=1.
